// File: rtl/cpu_debug_ctrl.sv
// Board-side run/debug controller: CPU clock-enable generation with run/step/halt
// control, plus a debounced up/down memory-address browser with auto-repeat.
module cpu_debug_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DIV_W     = 32,
  parameter int DIV_FAST  = 4,
  parameter int DIV_SLOW  = 976560,
  parameter int DEB_CYC   = 20,
  parameter int REP_DELAY = 1000,
  parameter int REP_RATE  = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_fast,
  input  logic              step_mode,
  input  logic              go,
  input  logic              addr_up,
  input  logic              addr_dn,
  input  logic              browse,
  input  logic              halt,
  output logic              cpu_ce,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STEP   = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE      = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_ZERO     = DEB_W'(0);
  localparam logic [REP_W-1:0]  REP_DELAY_V  = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0]  REP_RATE_V   = REP_W'(REP_RATE);
  localparam logic [REP_W-1:0]  REP_ONE      = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_ZERO     = REP_W'(0);
  localparam logic [DIV_W-1:0]  FAST_LAST    = DIV_W'(DIV_FAST - 1);
  localparam logic [DIV_W-1:0]  SLOW_LAST    = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ZERO     = DIV_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO    = ADDR_W'(0);

  // Button bit order: 0 = go, 1 = addr_up, 2 = addr_dn
  logic [2:0]        raw_s;
  logic [2:0]        sync1_r;
  logic [2:0]        sync2_r;
  logic [2:0]        level_r;
  logic [2:0]        level_d_r;
  logic [2:0]        press_s;
  logic [DEB_W-1:0]  deb_cnt_r [3];

  // Repeat index: 0 = addr_up, 1 = addr_dn
  logic [REP_W-1:0]  hold_r [2];
  logic [1:0]        phase_r;
  logic [1:0]        rep_s;
  logic              up_step_s;
  logic              dn_step_s;

  logic [DIV_W-1:0]  div_cnt_r;
  logic              fast_sel_r;
  logic              tick_s;

  state_t            state_r;
  logic              cpu_ce_r;
  logic [ADDR_W-1:0] mem_addr_r;

  assign raw_s     = {addr_dn, addr_up, go};
  assign press_s   = level_r & ~level_d_r;
  assign rep_s[0]  = level_r[1] & (hold_r[0] == (phase_r[0] ? REP_RATE_V : REP_DELAY_V));
  assign rep_s[1]  = level_r[2] & (hold_r[1] == (phase_r[1] ? REP_RATE_V : REP_DELAY_V));
  assign up_step_s = press_s[1] | rep_s[0];
  assign dn_step_s = press_s[2] | rep_s[1];
  assign tick_s    = (div_cnt_r == (fast_sel_r ? FAST_LAST : SLOW_LAST));

  // Synchronise and debounce the three buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      level_r   <= 3'b000;
      level_d_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_r[i] <= DEB_ZERO;
      end
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          deb_cnt_r[i] <= DEB_ZERO;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          level_r[i]   <= sync2_r[i];
          deb_cnt_r[i] <= DEB_ZERO;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
        end
      end
    end
  end

  // Hold counters: first repeat REP_DELAY after the press, then every REP_RATE
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= 2'b00;
      for (int j = 0; j < 2; j++) begin
        hold_r[j] <= REP_ZERO;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!level_r[j+1]) begin
          hold_r[j]  <= REP_ZERO;
          phase_r[j] <= 1'b0;
        end else if (rep_s[j]) begin
          hold_r[j]  <= REP_ONE;
          phase_r[j] <= 1'b1;
        end else begin
          hold_r[j]  <= hold_r[j] + REP_ONE;
        end
      end
    end
  end

  // Divider; the rate is re-latched only at wrap so a period is never cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r  <= DIV_ZERO;
      fast_sel_r <= run_fast;
    end else if (tick_s) begin
      div_cnt_r  <= DIV_ZERO;
      fast_sel_r <= run_fast;
    end else begin
      div_cnt_r  <= div_cnt_r + DIV_ONE;
    end
  end

  // Run/step/halt FSM with registered clock enable
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_RUN;
      cpu_ce_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cpu_ce_r <= tick_s;
          if (halt) begin
            state_r <= ST_HALTED;
          end else if (step_mode) begin
            state_r <= ST_STEP;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: begin
          cpu_ce_r <= press_s[0];
          if (halt) begin
            state_r <= ST_HALTED;
          end else if (!step_mode) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_STEP;
          end
        end
        ST_HALTED: begin
          cpu_ce_r <= press_s[0];
          if (press_s[0]) begin
            state_r <= step_mode ? ST_STEP : ST_RUN;
          end else begin
            state_r <= ST_HALTED;
          end
        end
        default: begin
          cpu_ce_r <= 1'b0;
          state_r  <= ST_RUN;
        end
      endcase
    end
  end

  // Browse address; simultaneous up and down steps cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r <= ADDR_ZERO;
    end else if (!browse) begin
      mem_addr_r <= ADDR_ZERO;
    end else if (up_step_s && !dn_step_s) begin
      mem_addr_r <= mem_addr_r + ADDR_ONE;
    end else if (dn_step_s && !up_step_s) begin
      mem_addr_r <= mem_addr_r - ADDR_ONE;
    end else begin
      mem_addr_r <= mem_addr_r;
    end
  end

  assign cpu_ce   = cpu_ce_r;
  assign state    = state_r;
  assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl with a timeline-based reference model and
// per-cycle output comparison, plus hand-computed expectations.
module tb_cpu_debug_ctrl;

  localparam int AW  = 4;
  localparam int DF  = 4;
  localparam int DS  = 10;
  localparam int DEB = 20;
  localparam int RD  = 50;
  localparam int RR  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_fast = 1'b1;
  logic          step_mode = 1'b0;
  logic          go = 1'b0;
  logic          addr_up = 1'b0;
  logic          addr_dn = 1'b0;
  logic          browse = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_ce;
  logic [AW-1:0] mem_addr;
  logic [1:0]    state;

  cpu_debug_ctrl #(
    .ADDR_W(AW), .DIV_W(32), .DIV_FAST(DF), .DIV_SLOW(DS),
    .DEB_CYC(DEB), .REP_DELAY(RD), .REP_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .run_fast(run_fast), .step_mode(step_mode),
    .go(go), .addr_up(addr_up), .addr_dn(addr_dn), .browse(browse),
    .halt(halt), .cpu_ce(cpu_ce), .mem_addr(mem_addr), .state(state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int edge_n = 0;
  int ce_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  // Reference model: absolute-time bookkeeping of debounce windows, press/repeat
  // times and divider wrap times.
  bit             valid = 1'b0;
  logic [DEB+1:0] hist [3];
  bit             lvl [3];
  int             rise_t [3];
  int             next_tick;
  bit             m_ce;
  logic [1:0]     m_state;
  logic [AW-1:0]  m_addr;

  always @(posedge clk) begin
    bit pr [3];
    bit rp [3];
    bit tick;
    int k;
    logic [2:0] raw;
    logic [DEB-1:0] win;
    edge_n++;
    raw = {addr_dn, addr_up, go};
    if (rst) begin
      valid = 1'b1;
      m_ce = 1'b0;
      m_state = 2'd0;
      m_addr = '0;
      for (int b = 0; b < 3; b++) begin
        hist[b] = '0;
        lvl[b] = 1'b0;
        rise_t[b] = 0;
      end
      next_tick = edge_n + (run_fast ? DF : DS);
    end else if (valid) begin
      for (int b = 0; b < 3; b++) begin
        pr[b] = 1'b0;
        rp[b] = 1'b0;
        if (lvl[b]) begin
          k = edge_n - rise_t[b] - 1;
          pr[b] = (k == 0);
          rp[b] = (b != 0) && (k >= RD) && (((k - RD) % RR) == 0);
        end
      end
      tick = (edge_n == next_tick);
      if (tick) next_tick = edge_n + (run_fast ? DF : DS);
      if (m_state == 2'd0) begin
        m_ce = tick;
        if (halt) m_state = 2'd2;
        else if (step_mode) m_state = 2'd1;
      end else if (m_state == 2'd1) begin
        m_ce = pr[0];
        if (halt) m_state = 2'd2;
        else if (!step_mode) m_state = 2'd0;
      end else begin
        m_ce = pr[0];
        if (pr[0]) m_state = step_mode ? 2'd1 : 2'd0;
      end
      if (!browse) m_addr = '0;
      else m_addr = AW'((int'(m_addr) + (1 << AW) + int'(pr[1] | rp[1]) - int'(pr[2] | rp[2])) % (1 << AW));
      for (int b = 0; b < 3; b++) begin
        hist[b] = {hist[b][DEB:0], raw[b]};
        win = hist[b][DEB+1:2];
        if (!lvl[b] && (&win)) begin
          lvl[b] = 1'b1;
          rise_t[b] = edge_n;
        end else if (lvl[b] && !(|win)) begin
          lvl[b] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (valid) begin
      chk("cpu_ce", int'(cpu_ce), int'(m_ce));
      chk("state", int'(state), int'(m_state));
      chk("mem_addr", int'(mem_addr), int'(m_addr));
    end
    if (cpu_ce === 1'b1) ce_count++;
  end

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ce(input string nm, output int t);
    bit got = 1'b0;
    t = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      nx();
      if (cpu_ce === 1'b1) begin
        got = 1'b1;
        t = edge_n;
      end
    end
    chk(nm, int'(got), 1);
  endtask

  task automatic press_btn(input bit u, input bit d, input int hold);
    addr_up = u;
    addr_dn = d;
    repeat (hold) nx();
    addr_up = 1'b0;
    addr_dn = 1'b0;
    repeat (30) nx();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, t3, tr, tp, base;
    repeat (3) nx();
    chk("reset_ce", int'(cpu_ce), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_addr", int'(mem_addr), 0);
    rst = 1'b0;

    // Rate select and mid-period switch
    wait_ce("rate_p0_seen", t0);
    wait_ce("rate_p1_seen", t1);
    chk("fast_period", t1 - t0, DF);
    nx();
    run_fast = 1'b0;
    wait_ce("rate_p2_seen", t2);
    chk("switch_period", t2 - t1, DF);
    wait_ce("rate_p3_seen", t3);
    chk("slow_period", t3 - t2, DS);

    // Debounce: bouncing go gives exactly one step, cpu_ce one cycle after the press
    step_mode = 1'b1;
    repeat (10) nx();
    base = ce_count;
    for (int i = 0; i < 10; i++) begin
      go = 1'b1;
      repeat (5) nx();
      go = 1'b0;
      repeat (5) nx();
    end
    tr = edge_n;
    go = 1'b1;
    wait_ce("deb_pulse_seen", tp);
    chk("deb_latency", tp - tr, DEB + 3);
    chk("deb_single", ce_count - base, 1);
    go = 1'b0;
    repeat (30) nx();

    // Single step
    base = ce_count;
    for (int i = 0; i < 3; i++) begin
      go = 1'b1;
      repeat (30) nx();
      go = 1'b0;
      repeat (30) nx();
    end
    chk("step_pulses", ce_count - base, 3);

    // Halt and resume
    step_mode = 1'b0;
    repeat (5) nx();
    halt = 1'b1;
    nx();
    nx();
    chk("halted_state", int'(state), 2);
    base = ce_count;
    repeat (1000) nx();
    chk("halt_no_ce", ce_count - base, 0);
    go = 1'b1;
    wait_ce("resume_a_seen", tp);
    chk("resume_a_state", int'(state), 0);
    nx();
    chk("rehalt_state", int'(state), 2);
    go = 1'b0;
    repeat (30) nx();
    halt = 1'b0;
    go = 1'b1;
    wait_ce("resume_b_seen", tp);
    chk("resume_b_state", int'(state), 0);
    repeat (5) nx();
    chk("run_state", int'(state), 0);
    go = 1'b0;
    repeat (30) nx();

    // Address wrap, cancelling presses, browse disable
    browse = 1'b1;
    nx();
    press_btn(1'b0, 1'b1, 30);
    chk("wrap_down", int'(mem_addr), 15);
    press_btn(1'b1, 1'b0, 30);
    chk("wrap_up", int'(mem_addr), 0);
    press_btn(1'b1, 1'b0, 30);
    chk("up_one", int'(mem_addr), 1);
    press_btn(1'b1, 1'b1, 30);
    chk("both_cancel", int'(mem_addr), 1);
    browse = 1'b0;
    nx();
    chk("browse_off", int'(mem_addr), 0);
    browse = 1'b1;
    nx();

    // Auto-repeat: press plus repeats at 50,60,...,100 cycles after it
    press_btn(1'b1, 1'b0, 105);
    chk("auto_repeat", int'(mem_addr), 7);

    // Reset mid-hold clears the address and the hold counter
    addr_up = 1'b1;
    repeat (100) nx();
    chk("pre_reset_hold", int'(mem_addr), 11);
    rst = 1'b1;
    nx();
    chk("reset_mid_addr", int'(mem_addr), 0);
    chk("reset_mid_state", int'(state), 0);
    rst = 1'b0;
    repeat (30) nx();
    chk("post_reset_press", int'(mem_addr), 1);
    repeat (30) nx();
    chk("no_stale_repeat", int'(mem_addr), 1);
    repeat (20) nx();
    chk("fresh_repeat", int'(mem_addr), 2);
    addr_up = 1'b0;
    repeat (30) nx();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
